// File: rtl/instr_byte_loader.sv
// Byte-serial program loader: packs 0xFE..0xFF framed bytes little-endian into instruction words.
// Optional trailing XOR checksum when LOADER_CHECKSUM_EN is defined.
module instr_byte_loader #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              instr_valid_i,
   input  logic [7:0]        instr_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              core_rst_o,
   output logic              load_done_o,
   output logic              load_err_o,
   output logic [ADDR_W:0]   word_count_o
);

   localparam logic [7:0]      StartByte = 8'hFE;
   localparam logic [7:0]      EndByte   = 8'hFF;
   localparam logic [ADDR_W:0] DepthCnt  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CntOne    = (ADDR_W+1)'(1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StLoad, StChk, StDone, StErr} state_e;
`else
   typedef enum logic [2:0] {StIdle, StLoad, StDone, StErr} state_e;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       part_q, part_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      part_d  = part_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (instr_valid_i && instr_i == StartByte) begin
               state_d = StLoad;
               cnt_d   = '0;
               idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         StLoad: begin
            if (instr_valid_i) begin
               if (idx_q == 2'd0 && instr_i == EndByte) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = StChk;
`else
                  state_d = StDone;
`endif
               end else if (idx_q == 2'd0 && cnt_q == DepthCnt) begin
                  // No room for another word: refuse before anything is written
                  state_d = StErr;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  csum_d = csum_q ^ instr_i;
`endif
                  idx_d = idx_q + 2'd1;
                  case (idx_q)
                     2'd0:    part_d[7:0]   = instr_i;
                     2'd1:    part_d[15:8]  = instr_i;
                     2'd2:    part_d[23:16] = instr_i;
                     default: begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = {instr_i, part_q};
                        cnt_d   = cnt_q + CntOne;
                     end
                  endcase
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         StChk: begin
            if (instr_valid_i) begin
               state_d = (instr_i == csum_q) ? StDone : StErr;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         part_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         part_q  <= part_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign word_count_o = cnt_q;
   assign core_rst_o   = (state_q != StDone);
   assign load_done_o  = (state_q == StDone);
   assign load_err_o   = (state_q == StErr);

endmodule

// File: tb/tb_instr_byte_loader.sv
// Directed and randomized bench for instr_byte_loader against a queue-based stream model.
module tb_instr_byte_loader;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 2;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   localparam int MIdle = 0, MLoad = 1, MChk = 2, MDone = 3, MErr = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              instr_valid_i = 1'b0;
   logic [7:0]        instr_i = 8'h00;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;
   logic              core_rst_o;
   logic              load_done_o;
   logic              load_err_o;
   logic [ADDR_W:0]   word_count_o;

   instr_byte_loader #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk_i         (clk),
      .reset         (reset),
      .instr_valid_i (instr_valid_i),
      .instr_i       (instr_i),
      .imem_we_o     (imem_we_o),
      .imem_addr_o   (imem_addr_o),
      .imem_wdata_o  (imem_wdata_o),
      .core_rst_o    (core_rst_o),
      .load_done_o   (load_done_o),
      .load_err_o    (load_err_o),
      .word_count_o  (word_count_o)
   );

   always #5 clk = ~clk;

   int          ncomp = 0;
   int          nfail = 0;
   int          m_mode = MIdle;
   int          m_cnt = 0;
   logic [7:0]  m_part[$];
   logic [7:0]  m_csum = 8'h00;
   bit          exp_we = 1'b0;
   bit          chk_data = 1'b0;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] exp_wdata = 32'h0;
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream semantics: framed payload bytes collect into a queue; four make a word.
   task automatic model_step(input bit rst, input bit v, input logic [7:0] b);
      exp_we   = 1'b0;
      chk_data = 1'b0;
      if (rst) begin
         m_mode = MIdle;
         m_cnt  = 0;
         m_part.delete();
         m_csum = 8'h00;
         exp_addr  = 32'h0;
         exp_wdata = 32'h0;
         chk_data  = 1'b1;
      end else if (v) begin
         case (m_mode)
            MIdle, MDone: begin
               if (b == 8'hFE) begin
                  m_mode = MLoad;
                  m_cnt  = 0;
                  m_part.delete();
                  m_csum = 8'h00;
               end
            end
            MLoad: begin
               if (m_part.size() == 0 && b == 8'hFF) begin
                  m_mode = CHK_EN ? MChk : MDone;
               end else if (m_part.size() == 0 && m_cnt == int'(DEPTH)) begin
                  m_mode = MErr;
               end else begin
                  m_csum ^= b;
                  m_part.push_back(b);
                  if (m_part.size() == 4) begin
                     exp_we    = 1'b1;
                     exp_addr  = 32'(m_cnt);
                     exp_wdata = {m_part[3], m_part[2], m_part[1], m_part[0]};
                     m_cnt++;
                     m_part.delete();
                  end
               end
            end
            MChk: m_mode = (b == m_csum) ? MDone : MErr;
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      chk("we", 32'(imem_we_o), 32'(exp_we));
      if (exp_we || chk_data) begin
         chk("addr", 32'(imem_addr_o), exp_addr);
         chk("wdata", imem_wdata_o, exp_wdata);
      end
      chk("word_count", 32'(word_count_o), 32'(m_cnt));
      chk("core_rst", 32'(core_rst_o), 32'(m_mode != MDone));
      chk("load_done", 32'(load_done_o), 32'(m_mode == MDone));
      chk("load_err", 32'(load_err_o), 32'(m_mode == MErr));
      if (imem_we_o) begin
         got_addr.push_back(32'(imem_addr_o));
         got_data.push_back(imem_wdata_o);
      end
   endtask

   task automatic cycle(input bit rst, input bit v, input logic [7:0] b);
      reset         = rst;
      instr_valid_i = v;
      instr_i       = b;
      @(posedge clk);
      model_step(rst, v, b);
      #1;
      check_outputs();
      reset         = 1'b0;
      instr_valid_i = 1'b0;
      instr_i       = 8'($urandom);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b0, 1'b1, b);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 8'h00);
      got_addr.delete();
      got_data.delete();
   endtask

   initial begin
      logic [7:0] b;
      int         n;
      int         nw;
      logic [7:0] basic[8];
      basic = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h33, 8'h05, 8'hB5, 8'h00};

      // Reset values
      do_reset();
      chk("rst_core_rst", 32'(core_rst_o), 32'h1);
      chk("rst_done", 32'(load_done_o), 32'h0);
      chk("rst_count", 32'(word_count_o), 32'h0);

      // Basic load
      send(8'hFE);
      for (int i = 0; i < 8; i++) send(basic[i]);
      send(8'hFF);
      chk("basic_nwrites", 32'(got_data.size()), 32'd2);
      chk("basic_w0", got_data[0], 32'h00A00513);
      chk("basic_a0", got_addr[0], 32'd0);
      chk("basic_w1", got_data[1], 32'h00B50533);
      chk("basic_a1", got_addr[1], 32'd1);
      chk("basic_count", 32'(word_count_o), 32'd2);
      chk("basic_done", 32'(load_done_o), 32'h1);
      chk("basic_core_rst", 32'(core_rst_o), 32'h0);

      // Reload from DONE holds the core again
      send(8'hFE);
      chk("reload_core_rst", 32'(core_rst_o), 32'h1);
      chk("reload_count", 32'(word_count_o), 32'h0);

      // Idle filtering and gaps
      do_reset();
      send(8'h00); send(8'h00); send(8'hAB);
      chk("idle_nwrites", 32'(got_data.size()), 32'd0);
      send(8'hFE);
      for (int i = 0; i < 8; i++) begin
         send(basic[i]);
         gap(3);
      end
      send(8'hFF);
      chk("gap_nwrites", 32'(got_data.size()), 32'd2);
      chk("gap_w0", got_data[0], 32'h00A00513);
      chk("gap_w1", got_data[1], 32'h00B50533);

      // In-word markers are payload
      do_reset();
      send(8'hFE); send(8'hFE); send(8'hFF); send(8'h12); send(8'h34); send(8'hFF);
      chk("marker_nwrites", 32'(got_data.size()), 32'd1);
      chk("marker_w0", got_data[0], 32'h3412FFFE);
      chk("marker_done", 32'(load_done_o), 32'h1);

      // Overflow at DEPTH words
      do_reset();
      send(8'hFE);
      for (int i = 0; i < 20; i++) send(8'(8'h10 + i));
      send(8'hFE); send(8'hFF);
      chk("ovf_nwrites", 32'(got_data.size()), 32'(DEPTH));
      chk("ovf_err", 32'(load_err_o), 32'h1);
      chk("ovf_core_rst", 32'(core_rst_o), 32'h1);
      chk("ovf_count", 32'(word_count_o), 32'(DEPTH));

      // Reset mid-word discards the partial word
      do_reset();
      send(8'hFE); send(8'h13); send(8'h05);
      do_reset();
      send(8'hFE); send(8'h93); send(8'h00); send(8'h10); send(8'h00); send(8'hFF);
      chk("midrst_nwrites", 32'(got_data.size()), 32'd1);
      chk("midrst_w0", got_data[0], 32'h00100093);
      chk("midrst_a0", got_addr[0], 32'd0);

`ifdef LOADER_CHECKSUM_EN
      do_reset();
      send(8'hFE); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'hFF);
      chk("csum_wait_done", 32'(load_done_o), 32'h0);
      send(8'h0F);
      chk("csum_ok_done", 32'(load_done_o), 32'h1);
      do_reset();
      send(8'hFE); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'hFF);
      send(8'h0E);
      chk("csum_bad_err", 32'(load_err_o), 32'h1);
      chk("csum_bad_done", 32'(load_done_o), 32'h0);
`endif

      // Randomized framed programs, every cycle checked against the model
      for (int it = 0; it < 40; it++) begin
         if (m_mode == MErr || $urandom_range(0, 3) == 0) do_reset();
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hFE) b = 8'h00;
            send(b);
         end
         send(8'hFE);
         nw = $urandom_range(0, DEPTH + 1);
         for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 4; j++) begin
               b = 8'($urandom);
               if (j == 0 && b == 8'hFF) b = 8'h7F;
               send(b);
               if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 3));
            end
         end
         if ($urandom_range(0, 5) == 0) send(8'($urandom));
         send(8'hFF);
         if (CHK_EN) send(($urandom_range(0, 3) == 0) ? 8'($urandom) : m_csum);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
